// File: rtl/leve_arb_pkg.sv
// leve_arb_pkg: shared types and constants for the AXI read arbiter
`ifndef XLEN
`define XLEN 32
`endif
package leve_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
  localparam int ARB_N = 2;
  localparam int REQ_IF = 0;
  localparam int REQ_LD = 1;
endpackage

// File: rtl/AXIR.sv
// AXIR: AXI read address/data channel bundle with initiator and target views
`ifndef XLEN
`define XLEN 32
`endif
interface AXIR;
  logic             ARVALID;
  logic             ARREADY;
  logic [`XLEN-1:0] ARADDR;
  logic             RVALID;
  logic             RREADY;
  logic [`XLEN-1:0] RDATA;
  logic [1:0]       RRESP;
  logic             RLAST;
  modport init (output ARVALID, ARADDR, RREADY, input ARREADY, RVALID, RDATA, RRESP, RLAST);
  modport target (input ARVALID, ARADDR, RREADY, output ARREADY, RVALID, RDATA, RRESP, RLAST);
endinterface

// File: rtl/leve_arb_pick.sv
// leve_arb_pick: one-hot winner select; LEVE_ARB_RR_EN gives round-robin, else requester 1 wins ties
module leve_arb_pick
  import leve_arb_pkg::*;
(
  input  logic [ARB_N-1:0] req,
`ifdef LEVE_ARB_RR_EN
  input  logic             last,
`endif
  output logic [ARB_N-1:0] win
);
`ifdef LEVE_ARB_RR_EN
  assign win = &req ? (last ? 2'b01 : 2'b10) : req;
`else
  assign win = req[REQ_LD] ? 2'b10 : req;
`endif
endmodule

// File: rtl/leve_axir_arb.sv
// leve_axir_arb: two-requester single-outstanding AXI read arbiter; LEVE_ARB_RR_EN selects round-robin
module leve_axir_arb
  import leve_arb_pkg::*;
(
  input  logic             CLK,
  input  logic             RSTn,
  AXIR.target              RII0,
  AXIR.target              RII1,
  AXIR.init                RIO,
  output logic [ARB_N-1:0] GRANT,
  output logic             BUSY
);
  arb_state_t state_q, state_d;
  logic [ARB_N-1:0] grant_q, grant_d, req, win;
  logic in_addr, in_data, own_arvalid, r_done;
`ifdef LEVE_ARB_RR_EN
  logic last_q, last_d;
`endif
  assign req = {RII1.ARVALID, RII0.ARVALID};
  leve_arb_pick u_pick (
    .req (req),
`ifdef LEVE_ARB_RR_EN
    .last(last_q),
`endif
    .win (win)
  );
  assign in_addr     = state_q == ADDR;
  assign in_data     = state_q == DATA;
  assign own_arvalid = grant_q[REQ_LD] ? RII1.ARVALID : RII0.ARVALID;
  assign RIO.ARVALID = in_addr & own_arvalid;
  assign RIO.ARADDR  = grant_q[REQ_LD] ? RII1.ARADDR : RII0.ARADDR;
  assign RIO.RREADY  = in_data & (grant_q[REQ_LD] ? RII1.RREADY : RII0.RREADY);
  assign RII0.ARREADY = in_addr & grant_q[REQ_IF] & RIO.ARREADY;
  assign RII1.ARREADY = in_addr & grant_q[REQ_LD] & RIO.ARREADY;
  assign RII0.RVALID  = in_data & grant_q[REQ_IF] & RIO.RVALID;
  assign RII1.RVALID  = in_data & grant_q[REQ_LD] & RIO.RVALID;
  assign RII0.RDATA   = RIO.RDATA;
  assign RII1.RDATA   = RIO.RDATA;
  assign RII0.RRESP   = RIO.RRESP;
  assign RII1.RRESP   = RIO.RRESP;
  assign RII0.RLAST   = RIO.RLAST;
  assign RII1.RLAST   = RIO.RLAST;
  assign r_done = in_data & RIO.RVALID & RIO.RREADY & RIO.RLAST;
  assign GRANT  = grant_q;
  assign BUSY   = state_q != IDLE;
  // dropping ARVALID in ADDR is a flush: abandon the grant without a downstream handshake
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifdef LEVE_ARB_RR_EN
    last_d = last_q;
`endif
    case (state_q)
      IDLE: if (|win) begin
        state_d = ADDR;
        grant_d = win;
`ifdef LEVE_ARB_RR_EN
        last_d = win[REQ_LD];
`endif
      end
      ADDR: if (!own_arvalid) begin
        state_d = IDLE;
        grant_d = '0;
      end else if (RIO.ARREADY) state_d = DATA;
      DATA: if (r_done) begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state_q <= IDLE;
      grant_q <= '0;
`ifdef LEVE_ARB_RR_EN
      last_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifdef LEVE_ARB_RR_EN
      last_q <= last_d;
`endif
    end
endmodule
